instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 24 ++
 rtl/instr_fetch_pc_next.sv | 34 +++
 rtl/instr_fetch.sv | 93 +++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: data widths, opcode
// constants, the fetch FSM state encoding and the default reset PC.
package instr_fetch_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPW   = 6;
    localparam int unsigned JTW   = 26;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Primary opcode field values, instr[31:26]
    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Combinational next-PC selection for the presented instruction.
// Ports:
//   pc            - address of the presented instruction
//   branch, zero  - control Branch and ALU zero flag
//   branch_offset - sign-extended word offset
//   jump          - control Jump (wins over branch)
//   jump_target   - instr[25:0]
//   next_pc_c     - selected next fetch address (combinational)
module instr_fetch_pc_next
    import instr_fetch_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            branch,
    input  logic            zero,
    input  logic [XLEN-1:0] branch_offset,
    input  logic            jump,
    input  logic [JTW-1:0]  jump_target,
    output logic [XLEN-1:0] next_pc_c
);

    logic [XLEN-1:0] pc_plus4;

    // All sums are XLEN bits wide so the address wraps modulo 2^32.
    always_comb begin
        pc_plus4  = pc + XLEN'(4);
        next_pc_c = pc_plus4;
        if (jump) begin
            next_pc_c = {pc_plus4[31:28], jump_target, 2'b00};
        end else if (branch && zero) begin
            next_pc_c = pc_plus4 + {branch_offset[XLEN-3:0], 2'b00};
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests one word at the PC, holds it for decode
// until consumed, then advances the PC (sequential, branch or jump).
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   imem_req/imem_addr              - memory read request and byte address
//   imem_ack/imem_rdata             - memory response
//   instr/opcode/pc/instr_valid     - instruction presented to decode
//   instr_ready                     - decode consumes the instruction
//   branch/zero/branch_offset/jump/jump_target - next-PC controls
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [OPW-1:0]  opcode,
    output logic [XLEN-1:0] pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            branch,
    input  logic            zero,
    input  logic [XLEN-1:0] branch_offset,
    input  logic            jump,
    input  logic [JTW-1:0]  jump_target
);

    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

    fetch_state_e    state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] next_pc_c;

    instr_fetch_pc_next u_pc_next (
        .pc            (pc_q),
        .branch        (branch),
        .zero          (zero),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .next_pc_c     (next_pc_c)
    );

    // Fetch FSM; the PC register doubles as the request address while in REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc_q        <= RESET_PC_ALIGNED;
            instr       <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    // Control inputs only matter on the transfer cycle.
                    if (instr_ready) begin
                        pc_q        <= next_pc_c;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= REQ;
                    end
                end
                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign opcode    = instr[31:26];

endmodule
